// File: rtl/pulse_gen_mc_pkg.sv
// Shared types and codes for the multi-channel pulse generator.
// Imported by the channel, the top and the bench.
package pulse_gen_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_CONT   = 2'd1,
        MODE_BURST  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    localparam logic [1:0] ADDR_PERIOD = 2'd0;
    localparam logic [1:0] ADDR_WIDTH  = 2'd1;
    localparam logic [1:0] ADDR_DELAY  = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

endpackage

// File: rtl/pulse_gen_mc_if.sv
// Config bus plus per-channel control strobes and pulse outputs.
// The master side drives config/start/stop; the slave side is the generator.
interface pulse_gen_mc_if #(
    parameter int NCH = 2,
    parameter int CW  = 16
);
    logic           cfg_we;
    logic [2:0]     cfg_ch;
    logic [1:0]     cfg_addr;
    logic [CW-1:0]  cfg_data;
    logic [NCH-1:0] start;
    logic [NCH-1:0] stop;
    logic [NCH-1:0] pulse_out;
    logic [NCH-1:0] cycle_mark;
    logic [NCH-1:0] busy;

    modport master (
        output cfg_we, cfg_ch, cfg_addr, cfg_data, start, stop,
        input  pulse_out, cycle_mark, busy
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_addr, cfg_data, start, stop,
        output pulse_out, cycle_mark, busy
    );
endinterface

// File: rtl/pulse_gen_mc_channel.sv
// One pulse channel: shadow config, active copies, IDLE/DELAY/RUN FSM and counters.
// Outputs are registered from the next-state values.
module pulse_gen_mc_channel
    import pulse_gen_mc_pkg::*;
#(
    parameter int CW    = 16,
    parameter int DEF_P = 1000,
    parameter int DEF_W = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_addr,
    input  logic [CW-1:0] cfg_data,
    input  logic          start,
    input  logic          stop,
    output logic          pulse_out,
    output logic          cycle_mark,
    output logic          busy
);
    localparam int RW = CW - 2;

    logic [CW-1:0] p_sh_q, p_sh_d, w_sh_q, w_sh_d, d_sh_q, d_sh_d;
    mode_e         mode_sh_q, mode_sh_d;
    logic [RW-1:0] burst_sh_q, burst_sh_d;

    logic [CW-1:0] p_act_q, p_act_d, w_act_q, w_act_d, d_act_q, d_act_d;
    mode_e         mode_act_q, mode_act_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d, dcnt_q, dcnt_d;
    state_e        state_q, state_d;
    logic          pulse_q, pulse_d, mark_q, mark_d, busy_q, busy_d;

    logic [CW-1:0] p_last_s, d_last_s;
    logic [RW-1:0] n_start_s;
    logic          mark_s;

    // Shadow register write decode.
    always_comb begin
        p_sh_d     = p_sh_q;
        w_sh_d     = w_sh_q;
        d_sh_d     = d_sh_q;
        mode_sh_d  = mode_sh_q;
        burst_sh_d = burst_sh_q;
        if (cfg_we) begin
            case (cfg_addr)
                ADDR_PERIOD: p_sh_d = cfg_data;
                ADDR_WIDTH:  w_sh_d = cfg_data;
                ADDR_DELAY:  d_sh_d = cfg_data;
                ADDR_CTRL: begin
                    mode_sh_d  = mode_e'(cfg_data[1:0]);
                    burst_sh_d = cfg_data[CW-1:2];
                end
                default: p_sh_d = p_sh_q;
            endcase
        end else begin
            p_sh_d = p_sh_q;
        end
    end

    // Compare values; a zero period behaves as one tick, a zero burst as one period.
    always_comb begin
        p_last_s = (p_act_q == {CW{1'b0}}) ? {CW{1'b0}} : (p_act_q - CW'(1));
        d_last_s = d_act_q - CW'(1);
        if (mode_sh_q == MODE_BURST) begin
            n_start_s = (burst_sh_q == {RW{1'b0}}) ? RW'(1) : burst_sh_q;
        end else begin
            n_start_s = RW'(1);
        end
    end

    // Channel FSM, counters and active-register reloads.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dcnt_d     = dcnt_q;
        rem_d      = rem_q;
        p_act_d    = p_act_q;
        w_act_d    = w_act_q;
        d_act_d    = d_act_q;
        mode_act_d = mode_act_q;
        mark_s     = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            cnt_d   = {CW{1'b0}};
            dcnt_d  = {CW{1'b0}};
        end else if (start) begin
            p_act_d    = p_sh_q;
            w_act_d    = w_sh_q;
            d_act_d    = d_sh_q;
            mode_act_d = mode_sh_q;
            rem_d      = n_start_s;
            cnt_d      = {CW{1'b0}};
            dcnt_d     = {CW{1'b0}};
            if (d_sh_q == {CW{1'b0}}) begin
                state_d = ST_RUN;
                mark_s  = 1'b1;
            end else begin
                state_d = ST_DELAY;
            end
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_DELAY: begin
                    if (tick) begin
                        if (dcnt_q == d_last_s) begin
                            state_d = ST_RUN;
                            cnt_d   = {CW{1'b0}};
                            mark_s  = 1'b1;
                        end else begin
                            dcnt_d = dcnt_q + CW'(1);
                        end
                    end else begin
                        dcnt_d = dcnt_q;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        if (cnt_q == p_last_s) begin
                            // Finite modes end here instead of wrapping once the count is spent.
                            if ((mode_act_q != MODE_CONT) && (rem_q <= RW'(1))) begin
                                state_d = ST_IDLE;
                                cnt_d   = {CW{1'b0}};
                            end else begin
                                cnt_d      = {CW{1'b0}};
                                rem_d      = (mode_act_q != MODE_CONT) ? (rem_q - RW'(1)) : rem_q;
                                p_act_d    = p_sh_q;
                                w_act_d    = w_sh_q;
                                d_act_d    = d_sh_q;
                                mode_act_d = mode_sh_q;
                                mark_s     = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output values taken from the next state so they line up with it.
    always_comb begin
        pulse_d = (state_d == ST_RUN) && (cnt_d < w_act_d);
        mark_d  = mark_s;
        busy_d  = (state_d != ST_IDLE);
    end

    // State, config and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_sh_q     <= CW'(DEF_P);
            w_sh_q     <= CW'(DEF_W);
            d_sh_q     <= {CW{1'b0}};
            mode_sh_q  <= MODE_SINGLE;
            burst_sh_q <= RW'(1);
            p_act_q    <= CW'(DEF_P);
            w_act_q    <= CW'(DEF_W);
            d_act_q    <= {CW{1'b0}};
            mode_act_q <= MODE_SINGLE;
            rem_q      <= RW'(1);
            cnt_q      <= {CW{1'b0}};
            dcnt_q     <= {CW{1'b0}};
            state_q    <= ST_IDLE;
            pulse_q    <= 1'b0;
            mark_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            p_sh_q     <= p_sh_d;
            w_sh_q     <= w_sh_d;
            d_sh_q     <= d_sh_d;
            mode_sh_q  <= mode_sh_d;
            burst_sh_q <= burst_sh_d;
            p_act_q    <= p_act_d;
            w_act_q    <= w_act_d;
            d_act_q    <= d_act_d;
            mode_act_q <= mode_act_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            dcnt_q     <= dcnt_d;
            state_q    <= state_d;
            pulse_q    <= pulse_d;
            mark_q     <= mark_d;
            busy_q     <= busy_d;
        end
    end

    assign pulse_out  = pulse_q;
    assign cycle_mark = mark_q;
    assign busy       = busy_q;

endmodule

// File: rtl/pulse_gen_mc.sv
// NCH-channel programmable pulse generator: shared tick prescaler,
// config channel decode and one pulse_gen_mc_channel per channel.
module pulse_gen_mc
    import pulse_gen_mc_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int CW       = 16,
    parameter int PRESCALE = 100,
    parameter int DEF_P    = 1000,
    parameter int DEF_W    = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         turbosim,
    pulse_gen_mc_if.slave bus
);
    localparam int             PSW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

    logic [PSW-1:0] presc_q, presc_d;
    logic           tick_s;
    logic [NCH-1:0] we_s, pulse_s, mark_s, busy_s;

    // Free-running prescaler; turbosim turns every clk into a tick.
    always_comb begin
        tick_s = (presc_q == PS_LAST) || turbosim;
        if (presc_q == PS_LAST) begin
            presc_d = {PSW{1'b0}};
        end else begin
            presc_d = presc_q + PSW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= {PSW{1'b0}};
        end else begin
            presc_q <= presc_d;
        end
    end

    // Channel select; codes at or above NCH match nothing and are dropped.
    always_comb begin
        we_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if (bus.cfg_we && (bus.cfg_ch == 3'(i))) begin
                we_s[i] = 1'b1;
            end else begin
                we_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pulse_gen_mc_channel #(
            .CW    (CW),
            .DEF_P (DEF_P),
            .DEF_W (DEF_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick_s),
            .cfg_we     (we_s[g]),
            .cfg_addr   (bus.cfg_addr),
            .cfg_data   (bus.cfg_data),
            .start      (bus.start[g]),
            .stop       (bus.stop[g]),
            .pulse_out  (pulse_s[g]),
            .cycle_mark (mark_s[g]),
            .busy       (busy_s[g])
        );
    end

    assign bus.pulse_out  = pulse_s;
    assign bus.cycle_mark = mark_s;
    assign bus.busy       = busy_s;

endmodule

// File: tb/tb_pulse_gen_mc.sv
// Directed bench for pulse_gen_mc; each check is an immediate assertion
// against a hand-derived expected value.
module tb_pulse_gen_mc;
    import pulse_gen_mc_pkg::*;

    localparam int NCH = 2;
    localparam int CW  = 16;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic turbosim = 1'b1;
    int   total    = 0;
    int   bad      = 0;

    pulse_gen_mc_if #(.NCH(NCH), .CW(CW)) dif ();

    pulse_gen_mc #(
        .NCH(NCH), .CW(CW), .PRESCALE(100), .DEF_P(1000), .DEF_W(1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .turbosim (turbosim),
        .bus      (dif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] ch, input logic [1:0] addr, input logic [CW-1:0] data);
        dif.cfg_we   = 1'b1;
        dif.cfg_ch   = ch;
        dif.cfg_addr = addr;
        dif.cfg_data = data;
        step();
        dif.cfg_we   = 1'b0;
    endtask

    initial begin
        int  mc;
        int  bc;
        int  pc;
        bit  ep;
        bit  em;
        dif.cfg_we   = 1'b0;
        dif.cfg_ch   = 3'd0;
        dif.cfg_addr = 2'd0;
        dif.cfg_data = '0;
        dif.start    = '0;
        dif.stop     = '0;

        // reset state
        step(); step();
        chk("rst_pulse", 32'(dif.pulse_out), 32'd0);
        chk("rst_mark",  32'(dif.cycle_mark), 32'd0);
        chk("rst_busy",  32'(dif.busy), 32'd0);
        reset = 1'b0;

        wr(3'd0, ADDR_PERIOD, 16'd10);
        wr(3'd0, ADDR_WIDTH,  16'd3);
        wr(3'd0, ADDR_CTRL,   16'd1);
        wr(3'd1, ADDR_PERIOD, 16'd4);
        wr(3'd1, ADDR_WIDTH,  16'd1);
        wr(3'd1, ADDR_DELAY,  16'd5);
        wr(3'd1, ADDR_CTRL,   16'd14);

        // ch0 continuous P=10 W=3 D=0
        dif.start = 2'b01; step(); dif.start = 2'b00;
        for (int k = 1; k <= 25; k++) begin
            ep = (k <= 3) || (k >= 11 && k <= 13) || (k >= 21 && k <= 23);
            em = (k == 1) || (k == 11) || (k == 21);
            chk($sformatf("cont_pulse_k%0d", k), 32'(dif.pulse_out[0]), 32'(ep));
            chk($sformatf("cont_mark_k%0d", k), 32'(dif.cycle_mark[0]), 32'(em));
            chk($sformatf("cont_ch1idle_k%0d", k), 32'(dif.busy[1]), 32'd0);
            step();
        end
        dif.stop = 2'b01; step(); dif.stop = 2'b00;
        chk("cont_stop_busy", 32'(dif.busy[0]), 32'd0);

        // ch1 burst of 3, P=4 W=1 D=5
        mc = 0;
        dif.start = 2'b10; step(); dif.start = 2'b00;
        for (int k = 1; k <= 20; k++) begin
            ep = (k == 6) || (k == 10) || (k == 14);
            chk($sformatf("burst_busy_k%0d", k), 32'(dif.busy[1]), 32'(k <= 17));
            chk($sformatf("burst_pulse_k%0d", k), 32'(dif.pulse_out[1]), 32'(ep));
            chk($sformatf("burst_mark_k%0d", k), 32'(dif.cycle_mark[1]), 32'(ep));
            mc += int'(dif.cycle_mark[1]);
            step();
        end
        chk("burst_mark_count", 32'(mc), 32'd3);

        // shadow writes: W=5 at t+4, P=0 at t+23
        dif.start = 2'b01; step(); dif.start = 2'b00;
        for (int k = 1; k <= 36; k++) begin
            ep = (k <= 3) || (k >= 11 && k <= 15) || (k >= 21 && k <= 25) || (k >= 31);
            em = (k == 1) || (k == 11) || (k == 21) || (k >= 31);
            chk($sformatf("shadow_pulse_k%0d", k), 32'(dif.pulse_out[0]), 32'(ep));
            chk($sformatf("shadow_mark_k%0d", k), 32'(dif.cycle_mark[0]), 32'(em));
            dif.cfg_we   = (k == 4) || (k == 23);
            dif.cfg_ch   = 3'd0;
            dif.cfg_addr = (k == 4) ? ADDR_WIDTH : ADDR_PERIOD;
            dif.cfg_data = (k == 4) ? 16'd5 : 16'd0;
            step();
        end
        dif.cfg_we = 1'b0;
        dif.stop = 2'b01; step(); dif.stop = 2'b00;
        wr(3'd0, ADDR_PERIOD, 16'd10);
        wr(3'd0, ADDR_WIDTH,  16'd3);

        // start and stop together: stop wins
        dif.start = 2'b01; dif.stop = 2'b01; step();
        dif.start = 2'b00; dif.stop = 2'b00;
        chk("ss_busy1", 32'(dif.busy[0]), 32'd0);
        chk("ss_pulse1", 32'(dif.pulse_out[0]), 32'd0);
        step();
        chk("ss_busy2", 32'(dif.busy[0]), 32'd0);

        // stop mid-pulse
        dif.start = 2'b01; step(); dif.start = 2'b00;
        chk("midstop_pulse_t1", 32'(dif.pulse_out[0]), 32'd1);
        step();
        chk("midstop_pulse_t2", 32'(dif.pulse_out[0]), 32'd1);
        dif.stop = 2'b01; step(); dif.stop = 2'b00;
        chk("midstop_pulse_t3", 32'(dif.pulse_out[0]), 32'd0);
        chk("midstop_busy_t3",  32'(dif.busy[0]), 32'd0);
        chk("midstop_mark_t3",  32'(dif.cycle_mark[0]), 32'd0);

        // writes to absent channels change nothing
        wr(3'd2, ADDR_PERIOD, 16'd2);
        wr(3'd2, ADDR_WIDTH,  16'd9);
        wr(3'd6, ADDR_PERIOD, 16'd5);
        dif.start = 2'b01; step(); dif.start = 2'b00;
        for (int k = 1; k <= 12; k++) begin
            ep = (k <= 3) || (k >= 11);
            em = (k == 1) || (k == 11);
            chk($sformatf("badch_pulse_k%0d", k), 32'(dif.pulse_out[0]), 32'(ep));
            chk($sformatf("badch_mark_k%0d", k), 32'(dif.cycle_mark[0]), 32'(em));
            step();
        end
        dif.stop = 2'b01; step(); dif.stop = 2'b00;

        // reset during RUN
        dif.start = 2'b01; step(); dif.start = 2'b00;
        step(); step(); step(); step();
        chk("midrst_busy_t5", 32'(dif.busy[0]), 32'd1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("midrst_pulse", 32'(dif.pulse_out), 32'd0);
        chk("midrst_mark",  32'(dif.cycle_mark), 32'd0);
        chk("midrst_busy",  32'(dif.busy), 32'd0);

        // default shadows: single 1000-tick period with a 1-tick pulse
        dif.start = 2'b01; step(); dif.start = 2'b00;
        chk("def_pulse_k1", 32'(dif.pulse_out[0]), 32'd1);
        chk("def_mark_k1",  32'(dif.cycle_mark[0]), 32'd1);
        step();
        chk("def_pulse_k2", 32'(dif.pulse_out[0]), 32'd0);
        mc = 0;
        bc = 0;
        for (int k = 2; k <= 1000; k++) begin
            mc += int'(dif.cycle_mark[0]);
            bc += int'(dif.busy[0]);
            step();
        end
        chk("def_marks_between", 32'(mc), 32'd0);
        chk("def_busy_count",    32'(bc), 32'd999);
        chk("def_busy_k1001",    32'(dif.busy[0]), 32'd0);
        chk("def_mark_k1001",    32'(dif.cycle_mark[0]), 32'd0);

        // prescaled ticks: P=3 W=1 single, prescaler aligned by reset
        turbosim = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
        wr(3'd0, ADDR_PERIOD, 16'd3);
        dif.start = 2'b01; step(); dif.start = 2'b00;
        chk("presc_pulse_first", 32'(dif.pulse_out[0]), 32'd1);
        pc = 0;
        bc = 0;
        for (int i = 0; i < 400; i++) begin
            pc += int'(dif.pulse_out[0]);
            bc += int'(dif.busy[0]);
            step();
        end
        chk("presc_pulse_clks", 32'(pc), 32'd98);
        chk("presc_busy_clks",  32'(bc), 32'd298);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
